// File: rtl/vcap_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vcap_pkg                                                   |
// | Brief   : Shared types and widths for the line packer and its FIFO.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package vcap_pkg;

  localparam int PXL_W  = 12;
  localparam int PACK_W = 16;
  localparam int WCNT_W = 11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LINE  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic              last;
    logic [PACK_W-1:0] data;
  } fifo_entry_t;

  // Zero-padded final word built from the bits still held at line end.
  function automatic logic [PACK_W-1:0] pack_residual(input logic [1:0] ph,
                                                      input logic [PXL_W-1:0] hold);
    logic [PACK_W-1:0] w;
    w = '0;
    case (ph)
      2'd1:    w = {hold, 4'h0};
      2'd2:    w = {hold[7:0], 8'h00};
      2'd3:    w = {hold[3:0], 12'h000};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vcap_line_pack_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vcap_line_pack_if                                          |
// | Brief   : Packed-word valid/ready stream towards the frame writer.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface vcap_line_pack_if;
  import vcap_pkg::*;

  logic [PACK_W-1:0] o_data;
  logic              o_last;
  logic              o_valid;
  logic              i_ready;

  modport master (output o_data, output o_last, output o_valid, input i_ready);
  modport slave  (input o_data, input o_last, input o_valid, output i_ready);

endinterface
`default_nettype wire

// File: rtl/vcap_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vcap_sync_fifo                                             |
// | Brief   : Single-clock show-ahead FIFO with registered head output.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module vcap_sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 17
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      head_q, head_d;
  logic                  valid_q;
  logic                  wr, rd;

  assign o_full    = (count_q == CNT_W'(DEPTH));
  assign o_empty   = ~valid_q;
  assign o_rd_data = head_q;

  always_comb begin
    rd       = i_rd_en & valid_q;
    wr       = i_wr_en & (~o_full | rd);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(rd);
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(wr);
    count_d  = count_q + CNT_W'(wr) - CNT_W'(rd);
    // The incoming word is the next head only when it lands on the read slot.
    head_d   = (wr && (wr_ptr_q == rd_ptr_d)) ? i_wr_data : mem_q[rd_ptr_d];
  end

  always_ff @(posedge i_clk) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      head_q   <= (count_d != '0) ? head_d : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vcap_line_pack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vcap_line_pack                                             |
// | Brief   : Packs RGB444 pixels 4:3 into 16-bit words, marks line ends |
// |           and queues words in a show-ahead FIFO.                     |
// |           Optional macro VCAP_PACK_OVF_EN adds overflow reporting.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module vcap_line_pack
  import vcap_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int LINE_BITS  = 9
) (
  input  logic                 i_pxl_clk,
  input  logic                 i_reset,
  input  logic [PXL_W-1:0]     i_pxl,
  input  logic                 i_active,
  input  logic                 i_active_negedge,
  input  logic [LINE_BITS-1:0] i_line,
  vcap_line_pack_if.master     out_if,
  output logic                 o_line_done,
  output logic [LINE_BITS-1:0] o_line_num,
  output logic [WCNT_W-1:0]    o_line_words,
  output logic                 o_overflow,
  output logic [7:0]           o_drop_cnt
);

  state_e               state_q;
  logic [1:0]           ph_q;
  logic [PXL_W-1:0]     hold_q;
  logic [PACK_W-1:0]    stg_q;
  logic                 stg_vld_q;
  fifo_entry_t          push_q;
  logic                 push_vld_q;
  logic [WCNT_W-1:0]    cnt_q;
  logic [LINE_BITS-1:0] line_cap_q;
  logic [LINE_BITS-1:0] line_num_q;
  logic [WCNT_W-1:0]    line_words_q;
  logic                 line_done_q;

  logic                 pxl_take_d;
  logic                 eol_d;
  logic                 word_vld_d;
  logic [PACK_W-1:0]    word_d;
  logic                 pop, wr_ok;
  logic                 fifo_full, fifo_empty;
  fifo_entry_t          fifo_head;

  always_comb begin
    pxl_take_d = i_active & ((state_q == S_IDLE) |
                             ((state_q == S_LINE) & ~i_active_negedge));
    eol_d      = (state_q == S_LINE) & i_active_negedge;
    word_vld_d = (pxl_take_d | eol_d) & (ph_q != 2'd0);
    case (ph_q)
      2'd1:    word_d = {hold_q, i_pxl[11:8]};
      2'd2:    word_d = {hold_q[7:0], i_pxl[11:4]};
      2'd3:    word_d = {hold_q[3:0], i_pxl};
      default: word_d = '0;
    endcase
    if (eol_d) begin
      word_d = pack_residual(ph_q, hold_q);
    end
  end

  always_ff @(posedge i_pxl_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      ph_q         <= 2'd0;
      hold_q       <= '0;
      stg_q        <= '0;
      stg_vld_q    <= 1'b0;
      push_q       <= '0;
      push_vld_q   <= 1'b0;
      cnt_q        <= '0;
      line_cap_q   <= '0;
      line_num_q   <= '0;
      line_words_q <= '0;
      line_done_q  <= 1'b0;
    end else begin
      push_vld_q  <= 1'b0;
      line_done_q <= 1'b0;

      // A new word displaces the staged one, which then heads for the FIFO.
      if (word_vld_d) begin
        push_vld_q  <= stg_vld_q;
        push_q.last <= 1'b0;
        push_q.data <= stg_q;
        stg_q       <= word_d;
        stg_vld_q   <= 1'b1;
        cnt_q       <= cnt_q + 11'd1;
      end

      if (pxl_take_d) begin
        ph_q <= ph_q + 2'd1;
        case (ph_q)
          2'd0:    hold_q <= i_pxl;
          2'd1:    hold_q <= {4'h0, i_pxl[7:0]};
          2'd2:    hold_q <= {8'h00, i_pxl[3:0]};
          default: hold_q <= hold_q;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          if (i_active) begin
            state_q    <= S_LINE;
            line_cap_q <= i_line;
            cnt_q      <= '0;
          end
        end
        S_LINE: begin
          if (i_active_negedge) begin
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          push_vld_q   <= stg_vld_q;
          push_q.last  <= 1'b1;
          push_q.data  <= stg_q;
          stg_vld_q    <= 1'b0;
          line_done_q  <= 1'b1;
          line_num_q   <= line_cap_q;
          line_words_q <= cnt_q;
          ph_q         <= 2'd0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pop   = ~fifo_empty & out_if.i_ready;
  assign wr_ok = push_vld_q & (~fifo_full | pop);

  vcap_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      ($bits(fifo_entry_t))
  ) u_fifo (
    .i_clk     (i_pxl_clk),
    .i_rst     (i_reset),
    .i_wr_en   (wr_ok),
    .i_wr_data (push_q),
    .i_rd_en   (out_if.i_ready),
    .o_rd_data (fifo_head),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  assign out_if.o_data  = fifo_head.data;
  assign out_if.o_last  = fifo_head.last;
  assign out_if.o_valid = ~fifo_empty;

  assign o_line_done  = line_done_q;
  assign o_line_num   = line_num_q;
  assign o_line_words = line_words_q;

`ifdef VCAP_PACK_OVF_EN
  logic       overflow_q;
  logic [7:0] drop_cnt_q;
  logic       drop;

  assign drop = push_vld_q & ~wr_ok;

  always_ff @(posedge i_pxl_clk) begin
    if (i_reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign o_overflow = overflow_q;
  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_overflow = 1'b0;
  assign o_drop_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vcap_line_pack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_vcap_line_pack                                          |
// | Brief   : Scoreboard bench for vcap_line_pack with bit-stream model. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_vcap_line_pack;

  localparam int DEPTH_LOG2 = 4;
  localparam int LINE_BITS  = 9;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } word_t;

  typedef struct {
    logic [LINE_BITS-1:0] n;
    logic [10:0]          w;
  } done_t;

  logic                 clk;
  logic                 rst;
  logic [11:0]          pxl;
  logic                 active;
  logic                 aneg;
  logic [LINE_BITS-1:0] line;
  logic                 line_done;
  logic [LINE_BITS-1:0] line_num;
  logic [10:0]          line_words;
  logic                 overflow;
  logic [7:0]           drop_cnt;

  vcap_line_pack_if out_if ();

  vcap_line_pack #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LINE_BITS  (LINE_BITS)
  ) dut (
    .i_pxl_clk        (clk),
    .i_reset          (rst),
    .i_pxl            (pxl),
    .i_active         (active),
    .i_active_negedge (aneg),
    .i_line           (line),
    .out_if           (out_if),
    .o_line_done      (line_done),
    .o_line_num       (line_num),
    .o_line_words     (line_words),
    .o_overflow       (overflow),
    .o_drop_cnt       (drop_cnt)
  );

  word_t       exp_q[$];
  done_t       done_q[$];
  logic [11:0] line_px[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          ready_mode = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Word w is bits [16w, 16w+15] of the MSB-first pixel bit stream, zero padded.
  function automatic logic [15:0] model_word(input int w);
    logic [15:0] r;
    logic [11:0] p;
    int          k;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      k = 16 * w + b;
      if (k < 12 * line_px.size()) begin
        p         = line_px[k / 12];
        r[15 - b] = p[11 - (k % 12)];
      end
    end
    return r;
  endfunction

  task automatic build_model(input logic [LINE_BITS-1:0] ln, input int keep);
    int    n;
    int    nw;
    word_t e;
    done_t dd;
    n  = line_px.size();
    nw = (12 * n + 15) / 16;
    for (int w = 0; w < nw; w++) begin
      e.d = model_word(w);
      e.l = (w == nw - 1);
      if (keep < 0 || w < keep) exp_q.push_back(e);
    end
    if (n > 0) begin
      dd.n = ln;
      dd.w = 11'(nw);
      done_q.push_back(dd);
    end
  endtask

  task automatic fill_rand(input int n);
    line_px.delete();
    for (int i = 0; i < n; i++) line_px.push_back(12'($urandom));
  endtask

  // gmode 0: back-to-back pixels, 1: random 0..2 gaps, 2: always 1..3 gaps.
  task automatic send_line(input int gmode, input int keep);
    logic [LINE_BITS-1:0] ln;
    int                   g;
    ln = LINE_BITS'($urandom);
    build_model(ln, keep);
    for (int i = 0; i < line_px.size(); i++) begin
      g = (gmode == 0) ? 0 : (gmode == 1) ? $urandom_range(0, 2) : $urandom_range(1, 3);
      for (int j = 0; j < g; j++) begin
        @(posedge clk); #1;
        active = 1'b0;
      end
      @(posedge clk); #1;
      active = 1'b1;
      pxl    = line_px[i];
      line   = (i == 0) ? ln : ~ln;
    end
    @(posedge clk); #1;
    active = 1'b0;
    aneg   = 1'b1;
    @(posedge clk); #1;
    aneg = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    ready_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && done_q.size() == 0 && !out_if.o_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst    = 1'b1;
    active = 1'b0;
    aneg   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    out_if.i_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       out_if.i_ready = ~out_if.i_ready;
        2:       out_if.i_ready = 1'($urandom_range(0, 1));
        3:       out_if.i_ready = 1'b0;
        default: out_if.i_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted word and every line end.
  initial begin
    word_t e;
    done_t d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_if.o_valid && out_if.i_ready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_word: got %h last=%0b, expected none",
                     out_if.o_data, out_if.o_last);
          end else begin
            e = exp_q.pop_front();
            chk("word", {15'd0, out_if.o_last, out_if.o_data}, {15'd0, e.l, e.d});
          end
        end
        if (line_done) begin
          if (done_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_line_done: got num=%0h words=%0d, expected none",
                     line_num, line_words);
          end else begin
            d = done_q.pop_front();
            chk("line_num", 32'(line_num), 32'(d.n));
            chk("line_words", 32'(line_words), 32'(d.w));
          end
        end
      end
    end
  end

  initial begin
    logic [LINE_BITS-1:0] ln;
    rst    = 1'b1;
    pxl    = '0;
    active = 1'b0;
    aneg   = 1'b0;
    line   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_if.o_valid), 32'd0);
    chk("rst_data", 32'(out_if.o_data), 32'd0);
    chk("rst_last", 32'(out_if.o_last), 32'd0);
    chk("rst_done", 32'(line_done), 32'd0);
    chk("rst_num", 32'(line_num), 32'd0);
    chk("rst_words", 32'(line_words), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    line_px = {12'hABC, 12'h123, 12'h456, 12'h789};
    send_line(0, -1);
    wait_drain();
    line_px = {12'hABC, 12'h123, 12'h456, 12'h789, 12'hDEF};
    send_line(1, -1);
    wait_drain();
    line_px = {12'h5A5};
    send_line(0, -1);
    wait_drain();

    // End-of-line pulse with no pixels must be ignored.
    @(posedge clk); #1;
    aneg = 1'b1;
    @(posedge clk); #1;
    aneg = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold_words", 32'(line_words), 32'd1);

    for (int l = 0; l < 30; l++) begin
      ready_mode = 2;
      fill_rand($urandom_range(1, 20));
      send_line(1, -1);
      wait_drain();
    end

    // Stalled consumer: 40 pixels give 30 words, only 16 fit.
    ready_mode = 3;
    repeat (2) @(posedge clk);
    fill_rand(40);
    send_line(0, 1 << DEPTH_LOG2);
    @(negedge clk);
    chk("ovf_done_seen", 32'(done_q.size()), 32'd0);
`ifdef VCAP_PACK_OVF_EN
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd14);
`else
    chk("ovf_flag", 32'(overflow), 32'd0);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    wait_drain();
    do_reset();
    @(negedge clk);
    chk("ovf_clear", 32'(overflow), 32'd0);
    chk("drop_clear", 32'(drop_cnt), 32'd0);

    // Half-rate consumer with sparse pixels: no drops allowed.
    ready_mode = 1;
    for (int l = 0; l < 2; l++) begin
      fill_rand(640);
      send_line(2, -1);
    end
    wait_drain();
    chk("toggle_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("toggle_ovf", 32'(overflow), 32'd0);

    // Reset during the 7th pixel discards the partial line.
    ready_mode = 3;
    repeat (2) @(posedge clk);
    ln = LINE_BITS'($urandom);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      active = 1'b1;
      pxl    = 12'($urandom);
      line   = ln;
      if (i == 6) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst    = 1'b0;
    active = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(out_if.o_valid), 32'd0);
    chk("rst_mid_words", 32'(line_words), 32'd0);
    @(posedge clk); #1;
    aneg = 1'b1;
    @(posedge clk); #1;
    aneg = 1'b0;
    repeat (5) @(posedge clk);
    ready_mode = 0;
    line_px = {12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666, 12'h777, 12'h888, 12'h999};
    send_line(0, -1);
    wait_drain();

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
